// File: rtl/dct2_2d_sequencer.sv
// dct2_2d_sequencer: vertical pass, drain, horizontal pass and drain for one WxH block; write side is a LAT-deep delay of the read side.
// Optional macro DCT2_2D_SEQ_OVERLAP_EN lets the next block start on the last HPASS cycle or during HDRAIN.
`default_nettype none

module dct2_2d_sequencer #(
  parameter int SIZE_BITS = 2,
  parameter int LAT       = 3,
  localparam int IDX_W    = 2 + 2**SIZE_BITS - 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SIZE_BITS-1:0] size_w,
  input  logic [SIZE_BITS-1:0] size_h,
  output logic                 ready,
  output logic                 enable,
  output logic                 read,
  output logic                 direction,
  output logic [SIZE_BITS-1:0] n_rd,
  output logic [IDX_W-1:0]     idx_rd,
  output logic                 write,
  output logic                 dir_wr,
  output logic [SIZE_BITS-1:0] n_wr,
  output logic [IDX_W-1:0]     idx_wr,
  output logic                 done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VPASS  = 3'd1,
    VDRAIN = 3'd2,
    HPASS  = 3'd3,
    HDRAIN = 3'd4
  } state_t;

  localparam int CW = $clog2(LAT) + 1;
  localparam int EW = 3 + SIZE_BITS + IDX_W;

  state_t               state;
  logic [SIZE_BITS-1:0] code_w, code_h;
  logic [CW-1:0]        drain_cnt;
  logic [IDX_W-1:0]     w_last, h_last;
  logic                 accept, last_h, drain_end, any_valid;
  logic [EW-1:0]        line_in;
  logic [EW-1:0]        line [LAT];

  // 4<<code - 1, computed modulo 2**IDX_W so the 32-point case yields 31.
  assign w_last    = (IDX_W'(4) << code_w) - IDX_W'(1);
  assign h_last    = (IDX_W'(4) << code_h) - IDX_W'(1);
  assign drain_end = (drain_cnt == CW'(LAT - 1));
  assign last_h    = (state == HPASS) && (idx_rd == h_last);

`ifdef DCT2_2D_SEQ_OVERLAP_EN
  assign ready = (state == IDLE) || (state == HDRAIN) || last_h;
`else
  assign ready = (state == IDLE);
`endif

  assign accept = start & ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      read      <= 1'b0;
      direction <= 1'b0;
      n_rd      <= '0;
      idx_rd    <= '0;
      code_w    <= '0;
      code_h    <= '0;
      drain_cnt <= '0;
    end else if (accept) begin
      state     <= VPASS;
      read      <= 1'b1;
      direction <= 1'b1;
      n_rd      <= size_h;
      idx_rd    <= '0;
      code_w    <= size_w;
      code_h    <= size_h;
    end else begin
      case (state)
        VPASS: begin
          if (idx_rd == w_last) begin
            state     <= VDRAIN;
            read      <= 1'b0;
            drain_cnt <= '0;
          end else begin
            idx_rd <= idx_rd + IDX_W'(1);
          end
        end
        VDRAIN: begin
          if (drain_end) begin
            state     <= HPASS;
            read      <= 1'b1;
            direction <= 1'b0;
            n_rd      <= code_w;
            idx_rd    <= '0;
          end else begin
            drain_cnt <= drain_cnt + CW'(1);
          end
        end
        HPASS: begin
          if (idx_rd == h_last) begin
            state     <= HDRAIN;
            read      <= 1'b0;
            drain_cnt <= '0;
          end else begin
            idx_rd <= idx_rd + IDX_W'(1);
          end
        end
        HDRAIN: begin
          if (drain_end) state <= IDLE;
          else           drain_cnt <= drain_cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write side: read-side fields delayed by exactly LAT cycles.
  assign line_in = {read, direction, n_rd, idx_rd, last_h};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) line[i] <= '0;
    end else begin
      line[0] <= line_in;
      for (int i = 1; i < LAT; i++) line[i] <= line[i-1];
    end
  end

  assign {write, dir_wr, n_wr, idx_wr, done} = line[LAT-1];

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < LAT; i++) any_valid = any_valid | line[i][EW-1];
  end

  assign enable = (state != IDLE) || any_valid;

endmodule

`default_nettype wire

// File: tb/tb_dct2_2d_sequencer.sv
// Scoreboard bench for dct2_2d_sequencer: expected read/write events are queued at accept time and checked as they emerge.
`default_nettype none

module tb_dct2_2d_sequencer;

  localparam int L = 3;
`ifdef DCT2_2D_SEQ_OVERLAP_EN
  localparam logic OVL = 1'b1;
`else
  localparam logic OVL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, mon_en;
  logic [1:0] size_w, size_h;
  logic       ready, enable, read, direction, write, dir_wr, done;
  logic [1:0] n_rd, n_wr;
  logic [4:0] idx_rd, idx_wr;

  logic       start1;
  logic [1:0] size_w1, size_h1, n_rd1, n_wr1;
  logic       ready1, enable1, read1, direction1, write1, dir_wr1, done1;
  logic [4:0] idx_rd1, idx_wr1;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic       dir;
    logic [1:0] n;
    logic [4:0] idx;
    logic       last;
  } ev_t;

  ev_t rdq[$];
  ev_t wrq[$];

  dct2_2d_sequencer #(.SIZE_BITS(2), .LAT(L)) dut (
    .clk(clk), .reset(reset), .start(start), .size_w(size_w), .size_h(size_h),
    .ready(ready), .enable(enable), .read(read), .direction(direction),
    .n_rd(n_rd), .idx_rd(idx_rd), .write(write), .dir_wr(dir_wr),
    .n_wr(n_wr), .idx_wr(idx_wr), .done(done)
  );

  dct2_2d_sequencer #(.SIZE_BITS(2), .LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .size_w(size_w1), .size_h(size_h1),
    .ready(ready1), .enable(enable1), .read(read1), .direction(direction1),
    .n_rd(n_rd1), .idx_rd(idx_rd1), .write(write1), .dir_wr(dir_wr1),
    .n_wr(n_wr1), .idx_wr(idx_wr1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (read === 1'b1) begin
        tests++;
        if (rdq.size() == 0) begin
          failed++;
          $display("FAIL rd_unexpected cyc=%0d dir=%0b n=%0d idx=%0d", cyc, direction, n_rd, idx_rd);
        end else begin
          e = rdq.pop_front();
          if (e.cyc != cyc || direction !== e.dir || n_rd !== e.n || idx_rd !== e.idx) begin
            failed++;
            $display("FAIL rd_event got cyc=%0d dir=%0b n=%0d idx=%0d want cyc=%0d dir=%0b n=%0d idx=%0d",
                     cyc, direction, n_rd, idx_rd, e.cyc, e.dir, e.n, e.idx);
          end
        end
      end else if (rdq.size() > 0 && rdq[0].cyc <= cyc) begin
        tests++; failed++;
        $display("FAIL rd_missing got read=%b want read at cyc=%0d idx=%0d", read, rdq[0].cyc, rdq[0].idx);
        void'(rdq.pop_front());
      end

      if (write === 1'b1) begin
        tests++;
        if (wrq.size() == 0) begin
          failed++;
          $display("FAIL wr_unexpected cyc=%0d dir=%0b n=%0d idx=%0d done=%0b", cyc, dir_wr, n_wr, idx_wr, done);
        end else begin
          e = wrq.pop_front();
          if (e.cyc != cyc || dir_wr !== e.dir || n_wr !== e.n || idx_wr !== e.idx || done !== e.last) begin
            failed++;
            $display("FAIL wr_event got cyc=%0d dir=%0b n=%0d idx=%0d done=%0b want cyc=%0d dir=%0b n=%0d idx=%0d done=%0b",
                     cyc, dir_wr, n_wr, idx_wr, done, e.cyc, e.dir, e.n, e.idx, e.last);
          end
        end
      end else begin
        if (wrq.size() > 0 && wrq[0].cyc <= cyc) begin
          tests++; failed++;
          $display("FAIL wr_missing got write=%b want write at cyc=%0d idx=%0d", write, wrq[0].cyc, wrq[0].idx);
          void'(wrq.pop_front());
        end
        if (done !== 1'b0) begin
          tests++; failed++;
          $display("FAIL done_without_write cyc=%0d got done=%b want 0", cyc, done);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_block(input int c0, input int w, input int h);
    ev_t e;
    int nw = 4 << w;
    int nh = 4 << h;
    for (int i = 0; i < nw; i++) begin
      e.cyc = c0 + 1 + i; e.dir = 1'b1; e.n = h[1:0]; e.idx = i[4:0]; e.last = 1'b0;
      rdq.push_back(e);
      e.cyc = e.cyc + L;
      wrq.push_back(e);
    end
    for (int i = 0; i < nh; i++) begin
      e.cyc = c0 + nw + L + 1 + i; e.dir = 1'b0; e.n = w[1:0]; e.idx = i[4:0]; e.last = (i == nh - 1);
      rdq.push_back(e);
      e.cyc = e.cyc + L;
      wrq.push_back(e);
    end
  endtask

  // Drive a one-cycle start in the current cycle; returns the accept cycle.
  task automatic accept(input int w, input int h, output int c0);
    start = 1'b1; size_w = w[1:0]; size_h = h[1:0];
    c0 = cyc;
    tests++;
    if (ready !== 1'b1) begin
      failed++;
      $display("FAIL accept_ready cyc=%0d got ready=%b want 1", cyc, ready);
    end
    push_block(c0, w, h);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rdq.size() != 0 || wrq.size() != 0 || ready !== 1'b1) && n < 400) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 400) begin
      failed++;
      $display("FAIL idle_timeout got rdq=%0d wrq=%0d want both 0", rdq.size(), wrq.size());
      rdq.delete(); wrq.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start1 = 1'b0; mon_en = 1'b0;
    size_w = '0; size_h = '0; size_w1 = '0; size_h1 = '0;
    tick(); tick();
    tests++;
    if ({read, write, enable, done, direction, dir_wr} !== 6'b0) begin
      failed++;
      $display("FAIL reset_flags got %b want 000000", {read, write, enable, done, direction, dir_wr});
    end
    tests++;
    if ({n_rd, n_wr, idx_rd, idx_wr} !== 14'b0) begin
      failed++;
      $display("FAIL reset_counts got %h want 0", {n_rd, n_wr, idx_rd, idx_wr});
    end
    tests++;
    if (ready !== 1'b1 || ready1 !== 1'b1) begin
      failed++;
      $display("FAIL reset_ready got %b%b want 11", ready, ready1);
    end
    reset = 1'b0;
    mon_en = 1'b1;
    tick();
  endtask

  task automatic test_8x8();
    int c0;
    accept(1, 1, c0);
    while (cyc < c0 + 22) tick();
    tests++;
    if (ready !== OVL) begin
      failed++;
      $display("FAIL ready_at_done got %b want %b", ready, OVL);
    end
    tick();
    tests++;
    if (ready !== 1'b1 || enable !== 1'b0) begin
      failed++;
      $display("FAIL ready_after_done got ready=%b enable=%b want 1 0", ready, enable);
    end
    wait_idle();
  endtask

  task automatic test_4x32();
    int c0;
    accept(0, 3, c0);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int c0, c1, early;
    early = 0;
    start = 1'b1; size_w = 2'd1; size_h = 2'd2;
    c0 = cyc;
    tests++;
    if (ready !== 1'b1) begin
      failed++;
      $display("FAIL b2b_first_ready got %b want 1", ready);
    end
    push_block(c0, 1, 2);
    c1 = c0 + 8 + 16 + 2 * L + 1;
    while (cyc < c1 - 1) begin
      tick();
      size_w = 2'($urandom_range(0, 3));
      size_h = 2'($urandom_range(0, 3));
      if (ready === 1'b1) early++;
    end
    tests++;
    if (early != 0) begin
      failed++;
      $display("FAIL b2b_ready_mid_block got %0d ready cycles want 0", early);
    end
    tick();
    size_w = 2'd2; size_h = 2'd0;
    tests++;
    if (ready !== 1'b1) begin
      failed++;
      $display("FAIL b2b_second_ready cyc=%0d got %b want 1", cyc, ready);
    end
    push_block(c1, 2, 0);
    tick();
    start = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int c0, n, dn;
    accept(1, 1, c0);
    n = 0;
    while (!(read === 1'b1 && direction === 1'b0 && idx_rd == 5'd5) && n < 60) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 60) begin
      failed++;
      $display("FAIL rst_mid_wait got no HPASS idx 5 want it within 60 cycles");
    end
    reset = 1'b1;
    tick();
    rdq.delete(); wrq.delete();
    tests++;
    if ({read, write, enable, done, direction, dir_wr, n_rd, n_wr, idx_rd, idx_wr} !== 20'b0 || ready !== 1'b1) begin
      failed++;
      $display("FAIL rst_mid_outputs got %h ready=%b want 0 ready=1",
               {read, write, enable, done, direction, dir_wr, n_rd, n_wr, idx_rd, idx_wr}, ready);
    end
    reset = 1'b0;
    dn = 0;
    repeat (20) begin
      tick();
      if (done === 1'b1 || write === 1'b1) dn++;
    end
    tests++;
    if (dn != 0) begin
      failed++;
      $display("FAIL rst_mid_after got %0d write/done cycles want 0", dn);
    end
  endtask

  task automatic test_overlap();
    int c0, c1;
    accept(2, 2, c0);
    c1 = c0 + 16 + L + 16;
    while (cyc < c1) tick();
    accept(2, 2, c1);
    wait_idle();
  endtask

  task automatic test_lat1();
    int c0, rc, wc, vexp, hexp, bad, maxi, done_cyc, rdy66, rdy67;
    rc = 0; wc = 0; vexp = 0; hexp = 0; bad = 0; maxi = 0; done_cyc = -1;
    start1 = 1'b1; size_w1 = 2'd3; size_h1 = 2'd3;
    c0 = cyc;
    tests++;
    if (ready1 !== 1'b1) begin
      failed++;
      $display("FAIL lat1_ready got %b want 1", ready1);
    end
    tick();
    start1 = 1'b0;
    rdy66 = -1; rdy67 = -1;
    while (cyc <= c0 + 80) begin
      if (read1 === 1'b1) begin
        rc++;
        if (idx_rd1 > maxi) maxi = idx_rd1;
        if (direction1) begin
          if (idx_rd1 != vexp) bad++;
          vexp++;
        end else begin
          if (idx_rd1 != hexp) bad++;
          hexp++;
        end
      end
      if (write1 === 1'b1) wc++;
      if (done1 === 1'b1) done_cyc = cyc;
      if (cyc == c0 + 66) rdy66 = ready1;
      if (cyc == c0 + 67) rdy67 = ready1;
      tick();
    end
    tests++;
    if (done_cyc != c0 + 66) begin
      failed++;
      $display("FAIL lat1_done got cycle %0d want %0d", done_cyc, c0 + 66);
    end
    tests++;
    if (rc != 64 || wc != 64) begin
      failed++;
      $display("FAIL lat1_counts got reads=%0d writes=%0d want 64 64", rc, wc);
    end
    tests++;
    if (bad != 0 || maxi != 31) begin
      failed++;
      $display("FAIL lat1_idx got bad=%0d max=%0d want 0 31", bad, maxi);
    end
    tests++;
    if (rdy67 != 1 || rdy66 != int'(OVL)) begin
      failed++;
      $display("FAIL lat1_ready_end got r66=%0d r67=%0d want %0d 1", rdy66, rdy67, OVL);
    end
  endtask

  initial begin
    test_reset();
    test_8x8();
    test_4x32();
`ifndef DCT2_2D_SEQ_OVERLAP_EN
    test_back_to_back();
`else
    test_overlap();
`endif
    test_reset_mid();
    test_lat1();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
